// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch display: FSM encoding, digit layout
// and BCD limits used by the counter and the scan multiplexer.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_e;

    localparam int DIGIT_COUNT = 6;

    localparam logic [3:0] BCD_UNITS_MAX = 4'd9;
    localparam logic [3:0] BCD_TENS_MAX  = 4'd5;

    // Digit positions inside time_bcd, least significant nibble first
    localparam logic [2:0] DIG_FR_U  = 3'd0;
    localparam logic [2:0] DIG_FR_T  = 3'd1;
    localparam logic [2:0] DIG_SEC_U = 3'd2;
    localparam logic [2:0] DIG_SEC_T = 3'd3;
    localparam logic [2:0] DIG_MIN_U = 3'd4;
    localparam logic [2:0] DIG_MIN_T = 3'd5;

    // Units digits (even index) count to 9, tens digits (odd index) to 5
    function automatic logic [3:0] digit_max(input logic [2:0] idx);
        if (idx[0]) begin
            return BCD_TENS_MAX;
        end else begin
            return BCD_UNITS_MAX;
        end
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous level, followed by a rising-edge
// detector producing a registered one-clock pulse per input rising edge.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_pulse
);

    // Fewer than two flops would not give the input time to settle
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;
    logic              pulse_q;
    logic              pulse_d;

    // Shift the input through the chain and flag a 0->1 step at its output
    always_comb begin
        sync_d  = {sync_q[STAGES-2:0], async_in};
        prev_d  = sync_q[STAGES-1];
        pulse_d = sync_q[STAGES-1] & ~prev_q;
    end

    // Synchronizer, history and pulse flops, all cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= {STAGES{1'b0}};
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign rise_pulse = pulse_q;

endmodule

// File: rtl/stopwatch_display.sv
// Stopwatch with mm:ss:ff BCD time (60 frames per second), start/stop and
// clear buttons, a sticky rollover flag and a six-digit display scanner.
module stopwatch_display
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_DIGITS  = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk60,
    input  logic        clk480,
    input  logic        btn_start_stop,
    input  logic        btn_clear,
    output logic [23:0] time_bcd,
    output logic        running,
    output logic        wrapped,
    output logic [2:0]  digit_sel,
    output logic [3:0]  digit_val
);

    localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);

    logic tick60;
    logic tick480;
    logic ev_ss;
    logic ev_clr;

    sw_state_e   state_q;
    sw_state_e   state_d;
    logic [23:0] time_q;
    logic [23:0] time_d;
    logic        wrapped_q;
    logic        wrapped_d;
    logic [2:0]  digit_sel_q;
    logic [2:0]  digit_sel_d;
    logic        carry;
    logic [3:0]  nib;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_60 (
        .clk(clk), .rst_n(rst_n), .async_in(clk60), .rise_pulse(tick60)
    );
    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_480 (
        .clk(clk), .rst_n(rst_n), .async_in(clk480), .rise_pulse(tick480)
    );
    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
        .clk(clk), .rst_n(rst_n), .async_in(btn_start_stop), .rise_pulse(ev_ss)
    );
    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clr (
        .clk(clk), .rst_n(rst_n), .async_in(btn_clear), .rise_pulse(ev_clr)
    );

    // Next state, next time and rollover flag; clear overrides everything
    always_comb begin
        state_d   = state_q;
        time_d    = time_q;
        wrapped_d = wrapped_q;
        carry     = 1'b0;
        nib       = 4'd0;
        if (ev_clr) begin
            state_d   = ST_IDLE;
            time_d    = 24'd0;
            wrapped_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ev_ss ? ST_RUN   : ST_IDLE;
                ST_RUN:   state_d = ev_ss ? ST_PAUSE : ST_RUN;
                ST_PAUSE: state_d = ev_ss ? ST_RUN   : ST_PAUSE;
                default:  state_d = ST_IDLE;
            endcase
            // Frames are counted by the state we are in now, so a start/stop
            // landing on the same cycle as a tick does not change its fate
            if ((state_q == ST_RUN) && tick60) begin
                carry = 1'b1;
                for (int i = 0; i < DIGIT_COUNT; i++) begin
                    nib = time_q[i*4 +: 4];
                    if (carry) begin
                        // >= also folds any illegal nibble back to zero
                        if (nib >= digit_max(3'(i))) begin
                            time_d[i*4 +: 4] = 4'd0;
                        end else begin
                            time_d[i*4 +: 4] = nib + 4'd1;
                            carry            = 1'b0;
                        end
                    end else begin
                        time_d[i*4 +: 4] = nib;
                    end
                end
                // Carry out of the top digit means 59:59:59 rolled to zero
                if (carry) begin
                    wrapped_d = 1'b1;
                end else begin
                    wrapped_d = wrapped_q;
                end
            end else begin
                time_d = time_q;
            end
        end
    end

    // Scan pointer steps on every 480 Hz tick regardless of run state
    always_comb begin
        digit_sel_d = digit_sel_q;
        if (tick480) begin
            if (digit_sel_q >= LAST_DIGIT) begin
                digit_sel_d = 3'd0;
            end else begin
                digit_sel_d = digit_sel_q + 3'd1;
            end
        end else begin
            digit_sel_d = digit_sel_q;
        end
    end

    // Control and time registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            time_q      <= 24'd0;
            wrapped_q   <= 1'b0;
            digit_sel_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            time_q      <= time_d;
            wrapped_q   <= wrapped_d;
            digit_sel_q <= digit_sel_d;
        end
    end

    // Select the nibble currently being shown on the display
    always_comb begin
        digit_val = 4'd0;
        case (digit_sel_q)
            DIG_FR_U:  digit_val = time_q[3:0];
            DIG_FR_T:  digit_val = time_q[7:4];
            DIG_SEC_U: digit_val = time_q[11:8];
            DIG_SEC_T: digit_val = time_q[15:12];
            DIG_MIN_U: digit_val = time_q[19:16];
            DIG_MIN_T: digit_val = time_q[23:20];
            default:   digit_val = 4'd0;
        endcase
    end

    assign time_bcd  = time_q;
    assign running   = (state_q == ST_RUN);
    assign wrapped   = wrapped_q;
    assign digit_sel = digit_sel_q;

endmodule

// File: doc/stopwatch_display.md
STOPWATCH_DISPLAY -- requirements
Module: stopwatch_display

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on each tick/button input (minimum 2).
REQ-002 SHALL have parameter NUM_DIGITS, default 6, number of BCD digits scanned (fixed at 6 in this release).
REQ-003 SHALL have port clk  input  1  system clock, 12.5 MHz; the block's one clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port clk60  input  1  60 Hz square wave from the clock divider; rising edge = one frame tick.
REQ-006 SHALL have port clk480  input  1  480 Hz square wave from the clock divider; rising edge = one digit-scan tick.
REQ-007 SHALL have port btn_start_stop  input  1  level; rising edge toggles run/pause.
REQ-008 SHALL have port btn_clear  input  1  level; rising edge clears time and stops.
REQ-009 SHALL have port time_bcd  output  24  {min_t, min_u, sec_t, sec_u, fr_t, fr_u}, 4-bit BCD each.
REQ-010 SHALL have port running  output  1  high only in state RUN.
REQ-011 SHALL have port wrapped  output  1  sticky flag, set when time rolls over 59:59:59 to 00:00:00.
REQ-012 SHALL have port digit_sel  output  3  index of the digit currently driven, 0 (fr_u) to 5 (min_t).
REQ-013 SHALL have port digit_val  output  4  BCD nibble of time_bcd selected by digit_sel.

Function
REQ-014 SHALL treat clk60, clk480 and both buttons as asynchronous, passing each through SYNC_STAGES flops followed by a rising-edge detector that gives a one-clk pulse (tick60, tick480, ev_ss, ev_clr).
REQ-015 SHALL produce each pulse exactly SYNC_STAGES+1 clk edges after the first clk edge that samples the input high, with exactly one pulse per input rising edge.
REQ-016 SHALL implement FSM states IDLE, RUN and PAUSE.
REQ-017 SHALL apply these transitions on ev_ss: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
REQ-018 SHALL, on ev_clr in any state, go to IDLE, zero time_bcd and clear wrapped; ev_clr SHALL win over a simultaneous ev_ss or tick60.
REQ-019 SHALL advance the time by one frame on each tick60 only in RUN, and ignore tick60 in IDLE and PAUSE.
REQ-020 SHALL count frames 00-59, seconds 00-59 and minutes 00-59, each as tens/units BCD, carrying on 59->00; digits SHALL never hold values outside these ranges.
REQ-021 SHALL, on the tick at 59:59:59, go to 00:00:00, set wrapped and stay in RUN.
REQ-022 SHALL register time_bcd, so it updates on the same clk edge that consumes tick60.
REQ-023 SHALL advance digit_sel on each tick480 in every state (0->1->...->5->0); the scan SHALL run even when stopped.
REQ-024 SHALL drive digit_val combinationally from digit_sel and time_bcd.
REQ-025 SHALL produce no more than one time increment per clk, even if tick60 and tick480 are coincident.

Reset
REQ-026 SHALL, while rst_n is low, asynchronously force: state IDLE, time_bcd 0, running 0, wrapped 0, digit_sel 0, digit_val 0, all synchronizer and edge-detector flops 0.
REQ-027 SHALL start synchronous operation on the first clk edge after rst_n deasserts; a clk60 or button already high at that point SHALL produce one pulse after synchronization.
REQ-028 SHALL, on reset during RUN, discard the time without completing any pending carry.

Structure
REQ-029 SHALL put the state encoding (2-bit), the digit count 6, the BCD limits (9, 5) and the digit index constants in shared package stopwatch_pkg.
REQ-030 SHALL use one sub-module, sync_edge_detect (parameter SYNC_STAGES; ports clk, rst_n, async_in, rise_pulse), instantiated four times.

Verification
REQ-031 Reset, then btn_start_stop pulse, then 60 clk60 rising edges -> time_bcd = 0x000100, running=1.
REQ-032 RUN preloaded to 59:59:58 (via ticks), then 2 clk60 edges -> 00:00:00, wrapped=1, running=1.
REQ-033 RUN at 00:00:10, then start_stop -> PAUSE; 5 clk60 edges -> time unchanged 0x000010; start_stop -> running=1.
REQ-034 ev_clr and tick60 in the same clk cycle while in RUN -> time_bcd=0, state IDLE, wrapped=0.
REQ-035 Time 12:34:56, then 6 clk480 edges -> digit_val sequence 6,5,4,3,2,1 with digit_sel 0..5, then digit_sel wraps to 0.
REQ-036 rst_n asserted mid-RUN at 00:03:21 -> all outputs 0 immediately (before the next clk edge); no tick counted after release until start_stop.
